// File: rtl/snake_grid_builder.sv
// snake_grid_builder: rasterises snake segment positions into a double-buffered occupancy grid
module snake_grid_builder #(
   parameter int GRID_W  = 16,
   parameter int GRID_H  = 16,
   parameter int POS_W   = 8,
   parameter int MAX_LEN = 256,
   parameter int IDX_W   = $clog2(MAX_LEN),
   parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_start,
   input  logic [LEN_W-1:0]         i_length,
   output logic                     o_rd_en,
   output logic [IDX_W-1:0]         o_rd_idx,
   input  logic [POS_W-1:0]         i_rd_pos,
   output logic [GRID_W*GRID_H-1:0] o_grid,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_head_hit,
   output logic                     o_oob
);
   localparam int N = GRID_W * GRID_H;
   localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, COMMIT} state_t;
   state_t           r_state, w_next;
   logic [LEN_W-1:0] r_len, w_len;
   logic [IDX_W-1:0] r_idx, r_idx_d;
   logic             r_vld_d, r_hit, r_oob;
   logic [POS_W-1:0] r_head;
   logic [N-1:0]     r_shadow;
   logic             w_accept, w_last, w_pos_oob;
   assign w_len     = (i_length > MAXL) ? MAXL : i_length;
   assign w_accept  = (r_state == IDLE) && i_start;
   assign w_last    = LEN_W'(r_idx) == r_len - LEN_W'(1);
   assign w_pos_oob = int'(i_rd_pos) >= N;
   assign o_rd_idx  = r_idx;
   // state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= IDLE;
      else         r_state <= w_next;
   end
   // next state and read enable
   always_comb begin
      w_next  = r_state;
      o_rd_en = 1'b0;
      w_next  = r_state == IDLE  ? (i_start ? (w_len == '0 ? DRAIN : RUN) : IDLE) :
                r_state == RUN   ? (w_last ? DRAIN : RUN) :
                r_state == DRAIN ? COMMIT : IDLE;
      o_rd_en = r_state == RUN;
   end
   // read pipeline, shadow rasterisation and commit to the visible outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_len      <= '0;
         r_idx      <= '0;
         r_idx_d    <= '0;
         r_vld_d    <= 1'b0;
         r_hit      <= 1'b0;
         r_oob      <= 1'b0;
         r_head     <= '0;
         r_shadow   <= '0;
         o_grid     <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_head_hit <= 1'b0;
         o_oob      <= 1'b0;
      end else begin
         r_vld_d <= o_rd_en;
         r_idx_d <= o_rd_idx;
         o_done  <= r_state == COMMIT;
         if (w_accept) begin
            r_len    <= w_len;
            r_idx    <= '0;
            r_shadow <= '0;
            r_hit    <= 1'b0;
            r_oob    <= 1'b0;
            o_busy   <= 1'b1;
         end
         if (r_state == RUN) r_idx <= r_idx + IDX_W'(1);
         if (r_vld_d) begin
            if (w_pos_oob) r_oob <= 1'b1;
            else           r_shadow <= r_shadow | (N'(1) << i_rd_pos);
            if (r_idx_d == '0)          r_head <= i_rd_pos;
            else if (i_rd_pos == r_head) r_hit <= 1'b1;
         end
         if (r_state == COMMIT) begin
            o_grid     <= r_shadow;
            o_head_hit <= r_hit;
            o_oob      <= r_oob;
            o_busy     <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_snake_grid_builder.sv
// tb_snake_grid_builder: scoreboard bench for the default 16x16 grid and a 10x10 variant
module tb_snake_grid_builder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic         rst, st_a, st_b;
   logic [8:0]   len_a, len_b;
   logic         rd_en_a, rd_en_b;
   logic [7:0]   idx_a, idx_b;
   logic [7:0]   pos_a;
   logic [6:0]   pos_b;
   logic [255:0] grid_a;
   logic [99:0]  grid_b;
   logic         busy_a, done_a, hit_a, oob_a, busy_b, done_b, hit_b, oob_b;
   logic [7:0]   mem_a [256];
   logic [6:0]   mem_b [256];
   int           cyc = 0, n_vec = 0, n_err = 0;
   typedef struct {logic [255:0] g; logic h; logic o; int t0; int lat;} exp_t;
   exp_t q_a[$], q_b[$];
   exp_t e_a, e_b;

   snake_grid_builder dut_a (
      .i_clk(clk), .i_reset(rst), .i_start(st_a), .i_length(len_a),
      .o_rd_en(rd_en_a), .o_rd_idx(idx_a), .i_rd_pos(pos_a), .o_grid(grid_a),
      .o_busy(busy_a), .o_done(done_a), .o_head_hit(hit_a), .o_oob(oob_a));

   snake_grid_builder #(.GRID_W(10), .GRID_H(10), .POS_W(7), .MAX_LEN(256)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_start(st_b), .i_length(len_b),
      .o_rd_en(rd_en_b), .o_rd_idx(idx_b), .i_rd_pos(pos_b), .o_grid(grid_b),
      .o_busy(busy_b), .o_done(done_b), .o_head_hit(hit_b), .o_oob(oob_b));

   // position stores with one-cycle read latency, plus a cycle counter
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en_a) pos_a <= mem_a[idx_a];
      if (rd_en_b) pos_b <= mem_b[idx_b];
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // scoreboard checkers: every done pulse must match the oldest expected frame
   always @(negedge clk) begin
      if (!rst && done_a) begin
         if (q_a.size() == 0) chk("a_spurious_done", 256'(done_a), 256'(0));
         else begin
            e_a = q_a.pop_front();
            chk("a_grid", grid_a, e_a.g);
            chk("a_head_hit", 256'(hit_a), 256'(e_a.h));
            chk("a_oob", 256'(oob_a), 256'(e_a.o));
            chk("a_latency", 256'(cyc - e_a.t0), 256'(e_a.lat));
            chk("a_busy_at_done", 256'(busy_a), 256'(0));
         end
      end
   end
   always @(negedge clk) begin
      if (!rst && done_b) begin
         if (q_b.size() == 0) chk("b_spurious_done", 256'(done_b), 256'(0));
         else begin
            e_b = q_b.pop_front();
            chk("b_grid", 256'(grid_b), e_b.g);
            chk("b_head_hit", 256'(hit_b), 256'(e_b.h));
            chk("b_oob", 256'(oob_b), 256'(e_b.o));
            chk("b_latency", 256'(cyc - e_b.t0), 256'(e_b.lat));
            chk("b_busy_at_done", 256'(busy_b), 256'(0));
         end
      end
   end

   // build expected frame from the store, start, optionally pulse start mid-run, await done
   task automatic run(input bit b, input int len, input bit glitch);
      exp_t e;
      int n = len > 256 ? 256 : len;
      int cells = b ? 100 : 256;
      logic [7:0] p, h;
      e.g = '0; e.h = 1'b0; e.o = 1'b0; e.lat = n + 2;
      h = b ? 8'(mem_b[0]) : mem_a[0];
      for (int i = 0; i < n; i++) begin
         p = b ? 8'(mem_b[i]) : mem_a[i];
         if (int'(p) >= cells) e.o = 1'b1;
         else e.g[p] = 1'b1;
         if (i > 0 && p == h) e.h = 1'b1;
      end
      @(negedge clk);
      if (b) begin st_b = 1'b1; len_b = 9'(len); end
      else   begin st_a = 1'b1; len_a = 9'(len); end
      @(posedge clk);
      #1;
      st_a = 1'b0; st_b = 1'b0;
      e.t0 = cyc;
      if (b) q_b.push_back(e); else q_a.push_back(e);
      chk(b ? "b_busy" : "a_busy", 256'(b ? busy_b : busy_a), 256'(1));
      if (glitch) begin
         repeat (1) @(posedge clk);
         @(negedge clk);
         if (b) begin st_b = 1'b1; len_b = 9'd2; end
         else   begin st_a = 1'b1; len_a = 9'd2; end
         @(posedge clk);
         #1;
         st_a = 1'b0; st_b = 1'b0;
      end
      for (int k = 0; k < 400; k++) begin
         @(posedge clk);
         #2;
         if ((b ? q_b.size() : q_a.size()) == 0) break;
      end
      if ((b ? q_b.size() : q_a.size()) != 0) begin
         chk(b ? "b_done_timeout" : "a_done_timeout", 256'(b ? q_b.size() : q_a.size()), 256'(0));
         if (b) q_b.delete(); else q_a.delete();
      end
      repeat (6) @(posedge clk);
      #1;
      chk(b ? "b_grid_hold" : "a_grid_hold", b ? 256'(grid_b) : grid_a, e.g);
   endtask

   initial begin
      rst = 1'b1; st_a = 1'b0; st_b = 1'b0; len_a = '0; len_b = '0;
      for (int i = 0; i < 256; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grid", grid_a, '0);
      chk("rst_flags", {busy_a, done_a, hit_a, oob_a, rd_en_a}, '0);
      chk("rst_idx", 256'(idx_a), '0);
      chk("rst_b", {grid_b, busy_b, done_b, hit_b, oob_b, rd_en_b}, '0);
      @(negedge clk);
      rst = 1'b0;
      mem_a[0] = 8'd10; mem_a[1] = 8'd26; mem_a[2] = 8'd42; mem_a[3] = 8'd58;
      run(1'b0, 3, 1'b0);
      mem_a[0] = 8'd0; mem_a[1] = 8'd255; mem_a[2] = 8'd78; mem_a[3] = 8'd23;
      run(1'b0, 4, 1'b0);
      run(1'b0, 0, 1'b0);
      mem_a[0] = 8'd17; mem_a[1] = 8'd18; mem_a[2] = 8'd34; mem_a[3] = 8'd33; mem_a[4] = 8'd17;
      run(1'b0, 5, 1'b0);
      run(1'b0, 5, 1'b1);
      for (int i = 0; i < 256; i++) mem_a[i] = 8'($urandom_range(0, 255));
      run(1'b0, 20, 1'b0);
      run(1'b0, 300, 1'b0);
      @(negedge clk);
      st_a = 1'b1; len_a = 9'd10;
      @(posedge clk);
      #1;
      st_a = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_grid", grid_a, '0);
      chk("abort_busy", 256'(busy_a), '0);
      chk("abort_done", 256'(done_a), '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      mem_a[0] = 8'd200; mem_a[1] = 8'd201; mem_a[2] = 8'd200;
      run(1'b0, 3, 1'b0);
      mem_b[0] = 7'd99; mem_b[1] = 7'd120;
      run(1'b1, 2, 1'b0);
      for (int i = 0; i < 256; i++) mem_b[i] = 7'($urandom_range(0, 127));
      run(1'b1, 300, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
